rsa_core_arbiter: RTL and testbench

- Shares one iterative RSA exponentiation core among NUM_REQ independent requesters.
- Grants requesters round-robin and registers the winning job (msg, key, modulus).
- Issues the job to the core over a valid/ready handshake, captures the result, and returns it to the owning requester only.
- Allows exactly one job in flight; sits between client ports and the core's input and output handshakes.

---
 rtl/rsa_core_arbiter_if.sv | 43 ++++
 rtl/rsa_core_arbiter.sv | 117 +++++++++++
 tb/tb_rsa_core_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_core_arbiter_if.sv
// Requester, core and status signals of rsa_core_arbiter.
// master is the arbiter's view; slave is the requesters-plus-core view.
interface rsa_core_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int MOD_WIDTH = 256,
  parameter int CNT_WIDTH = 16
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*MOD_WIDTH-1:0] req_msg;
  logic [NUM_REQ*MOD_WIDTH-1:0] req_key;
  logic [NUM_REQ*MOD_WIDTH-1:0] req_modulus;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [MOD_WIDTH-1:0]         rsp_out;
  logic                         core_i_valid;
  logic                         core_i_ready;
  logic [MOD_WIDTH-1:0]         core_msg;
  logic [MOD_WIDTH-1:0]         core_key;
  logic [MOD_WIDTH-1:0]         core_modulus;
  logic                         core_o_valid;
  logic                         core_o_ready;
  logic [MOD_WIDTH-1:0]         core_out;
  logic                         busy;
  logic [OW-1:0]                owner;
  logic [CNT_WIDTH-1:0]         done_cnt;

  modport master (
    input  req_valid, req_msg, req_key, req_modulus, rsp_ready,
           core_i_ready, core_o_valid, core_out,
    output req_ready, rsp_valid, rsp_out, core_i_valid, core_msg, core_key,
           core_modulus, core_o_ready, busy, owner, done_cnt
  );

  modport slave (
    output req_valid, req_msg, req_key, req_modulus, rsp_ready,
           core_i_ready, core_o_valid, core_out,
    input  req_ready, rsp_valid, rsp_out, core_i_valid, core_msg, core_key,
           core_modulus, core_o_ready, busy, owner, done_cnt
  );
endinterface

// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one iterative RSA core among NUM_REQ requesters,
// with a single job in flight from grant through response handshake.
module rsa_core_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MOD_WIDTH = 256,
  parameter int CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  rsa_core_arbiter_if.master bus
);
  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        rr_last_q, owner_q;
  logic [MOD_WIDTH-1:0] msg_q, key_q, mod_q, rsp_q;
  logic [CNT_WIDTH-1:0] done_cnt_q;

  logic                 grant_vld;
  logic [OW-1:0]        grant_idx;
  logic [OW:0]          rr_sum;
  logic [MOD_WIDTH-1:0] grant_msg, grant_key, grant_mod;
  logic                 accept, issue_hs, result_hs, rsp_hs;

  // Walk downward from the farthest candidate so the nearest one after rr_last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_sum = {1'b0, rr_last_q} + (OW+1)'(k);
      if (rr_sum >= (OW+1)'(NUM_REQ)) rr_sum = rr_sum - (OW+1)'(NUM_REQ);
      if (bus.req_valid[rr_sum[OW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_sum[OW-1:0];
      end
    end
  end

  always_comb begin
    grant_msg = '0;
    grant_key = '0;
    grant_mod = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == OW'(i)) begin
        grant_msg = bus.req_msg[i*MOD_WIDTH +: MOD_WIDTH];
        grant_key = bus.req_key[i*MOD_WIDTH +: MOD_WIDTH];
        grant_mod = bus.req_modulus[i*MOD_WIDTH +: MOD_WIDTH];
      end
    end
  end

  assign accept    = (state_q == IDLE)  && grant_vld;
  assign issue_hs  = (state_q == ISSUE) && bus.core_i_ready;
  assign result_hs = (state_q == WAIT)  && bus.core_o_valid;
  assign rsp_hs    = (state_q == RESP)  && bus.rsp_ready[owner_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = ISSUE;
      ISSUE:   if (issue_hs)  state_d = WAIT;
      WAIT:    if (result_hs) state_d = RESP;
      RESP:    if (rsp_hs)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Requester fields are sampled only on the accept edge; later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q  <= OW'(NUM_REQ - 1);
      owner_q    <= '0;
      msg_q      <= '0;
      key_q      <= '0;
      mod_q      <= '0;
      rsp_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      if (accept) begin
        rr_last_q <= grant_idx;
        owner_q   <= grant_idx;
        msg_q     <= grant_msg;
        key_q     <= grant_key;
        mod_q     <= grant_mod;
      end
      if (result_hs) rsp_q <= bus.core_out;
      if (rsp_hs)    done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (grant_idx == OW'(i));
      bus.rsp_valid[i] = (state_q == RESP) && (owner_q == OW'(i));
    end
  end

  assign bus.core_i_valid = (state_q == ISSUE);
  assign bus.core_o_ready = (state_q == WAIT);
  assign bus.core_msg     = msg_q;
  assign bus.core_key     = key_q;
  assign bus.core_modulus = mod_q;
  assign bus.rsp_out      = rsp_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.owner        = owner_q;
  assign bus.done_cnt     = done_cnt_q;
endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: transaction-level model, core stub computing
// modular exponentiation, and directed scenarios with literal checkpoints.
module tb_rsa_core_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int MOD_WIDTH = 32;
  localparam int CNT_WIDTH = 4;
  localparam int CORE_LAT  = 5;
  localparam int WAIT_MAX  = 400;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rsa_core_arbiter_if #(.NUM_REQ(NUM_REQ), .MOD_WIDTH(MOD_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus();

  rsa_core_arbiter #(.NUM_REQ(NUM_REQ), .MOD_WIDTH(MOD_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int stallCycles = 0;
  int grantLog[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: actual=timeout required=event at %0t", name, $time);
  endtask

  function automatic logic [MOD_WIDTH-1:0] modexp(input logic [MOD_WIDTH-1:0] b,
                                                   input logic [MOD_WIDTH-1:0] e,
                                                   input logic [MOD_WIDTH-1:0] m);
    longint unsigned r, x, mm;
    if (m == 0) return '0;
    mm = 64'(m);
    r  = 1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < MOD_WIDTH; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return MOD_WIDTH'(r);
  endfunction

  function automatic logic [MOD_WIDTH-1:0] sliceOf(input logic [NUM_REQ*MOD_WIDTH-1:0] v, input int i);
    return v[i*MOD_WIDTH +: MOD_WIDTH];
  endfunction

  function automatic int pickGrant(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int onehotIdx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transaction-level model: one job record progressing through issue, result and return.
  bit                   mHaveJob, mIssued, mHaveResult;
  int                   mOwner, mRrLast, mDone, mGrant;
  logic [MOD_WIDTH-1:0] mMsg, mKey, mMod, mResult;

  always_comb mGrant = pickGrant(mRrLast, bus.req_valid);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mHaveJob <= 0; mIssued <= 0; mHaveResult <= 0;
      mOwner <= 0; mRrLast <= NUM_REQ - 1; mDone <= 0;
      mMsg <= '0; mKey <= '0; mMod <= '0; mResult <= '0;
    end else if (!mHaveJob) begin
      if (mGrant >= 0) begin
        mHaveJob <= 1; mIssued <= 0; mHaveResult <= 0;
        mOwner <= mGrant; mRrLast <= mGrant;
        mMsg <= sliceOf(bus.req_msg, mGrant);
        mKey <= sliceOf(bus.req_key, mGrant);
        mMod <= sliceOf(bus.req_modulus, mGrant);
      end
    end else if (!mIssued) begin
      if (bus.core_i_ready) mIssued <= 1;
    end else if (!mHaveResult) begin
      if (bus.core_o_valid) begin
        mHaveResult <= 1;
        mResult <= bus.core_out;
      end
    end else if (bus.rsp_ready[mOwner]) begin
      mHaveJob <= 0;
      mDone <= (mDone + 1) % (1 << CNT_WIDTH);
    end
  end

  function automatic logic [NUM_REQ-1:0] expReqReady();
    if (!mHaveJob && mGrant >= 0) return NUM_REQ'(1) << mGrant;
    return '0;
  endfunction

  function automatic logic [NUM_REQ-1:0] expRspValid();
    if (mHaveJob && mHaveResult) return NUM_REQ'(1) << mOwner;
    return '0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy",         bus.busy,         mHaveJob);
      checkOutput("req_ready",    bus.req_ready,    expReqReady());
      checkOutput("rsp_valid",    bus.rsp_valid,    expRspValid());
      checkOutput("core_i_valid", bus.core_i_valid, mHaveJob && !mIssued);
      checkOutput("core_o_ready", bus.core_o_ready, mHaveJob && mIssued && !mHaveResult);
      checkOutput("core_msg",     bus.core_msg,     mMsg);
      checkOutput("core_key",     bus.core_key,     mKey);
      checkOutput("core_modulus", bus.core_modulus, mMod);
      checkOutput("rsp_out",      bus.rsp_out,      mResult);
      checkOutput("owner",        bus.owner,        mOwner);
      checkOutput("done_cnt",     bus.done_cnt,     mDone);
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.req_ready != 0) grantLog.push_back(onehotIdx(bus.req_ready));
  end

  // Core stub: holds core_i_ready low for stallCycles, answers CORE_LAT cycles after accept.
  int                   stallLeft, countdown;
  bit                   stalling, acc, del;
  logic [MOD_WIDTH-1:0] pending;

  initial begin
    bus.core_i_ready = 0; bus.core_o_valid = 0; bus.core_out = '0;
    countdown = 0; stalling = 0; stallLeft = 0; pending = '0;
    forever begin
      @(negedge clk);
      acc = bus.core_i_valid && bus.core_i_ready;
      del = bus.core_o_valid && bus.core_o_ready;
      if (acc) pending = modexp(bus.core_msg, bus.core_key, bus.core_modulus);
      @(posedge clk); #1;
      if (rst) begin
        bus.core_i_ready = 0; bus.core_o_valid = 0; countdown = 0; stalling = 0;
      end else begin
        if (del) bus.core_o_valid = 0;
        if (acc) begin
          bus.core_i_ready = 0; stalling = 0; countdown = CORE_LAT;
        end else if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            bus.core_o_valid = 1; bus.core_out = pending;
          end
        end
        if (!acc && bus.core_i_valid && !bus.core_i_ready) begin
          if (!stalling) begin
            stalling = 1; stallLeft = stallCycles;
          end
          if (stallLeft > 0) stallLeft--;
          else bus.core_i_ready = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [MOD_WIDTH-1:0] msg,
                               input logic [MOD_WIDTH-1:0] key, input logic [MOD_WIDTH-1:0] md);
    bus.req_msg[idx*MOD_WIDTH +: MOD_WIDTH]     = msg;
    bus.req_key[idx*MOD_WIDTH +: MOD_WIDTH]     = key;
    bus.req_modulus[idx*MOD_WIDTH +: MOD_WIDTH] = md;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1; bus.req_valid = '0; bus.rsp_ready = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic waitRsp(input string name);
    int n = 0;
    while (bus.rsp_valid == 0) begin
      if (n >= WAIT_MAX) begin
        timeoutFail(name);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Ends at the negedge just after the n-th response handshake edge.
  task automatic waitResponses(input int n, input bit dropReq, input string name);
    int seen = 0;
    int cyc = 0;
    while (seen < n) begin
      @(negedge clk);
      if ((bus.rsp_valid & bus.rsp_ready) != 0) seen++;
      cyc++;
      if (cyc > WAIT_MAX * n) begin
        timeoutFail(name);
        return;
      end
    end
    @(posedge clk); #1;
    if (dropReq) bus.req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int expOrder[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1;
    bus.req_valid = '0; bus.req_msg = '0; bus.req_key = '0; bus.req_modulus = '0;
    bus.rsp_ready = '1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",         bus.busy,         0);
    checkOutput("rst_req_ready",    bus.req_ready,    0);
    checkOutput("rst_rsp_valid",    bus.rsp_valid,    0);
    checkOutput("rst_core_i_valid", bus.core_i_valid, 0);
    checkOutput("rst_core_o_ready", bus.core_o_ready, 0);
    checkOutput("rst_owner",        bus.owner,        0);
    checkOutput("rst_done_cnt",     bus.done_cnt,     0);
    checkOutput("rst_rsp_out",      bus.rsp_out,      0);
    @(posedge clk); #1;
    rst = 0;

    // Single job from requester 2: 4^13 mod 497 = 445.
    applyStimulus(2, 4, 13, 497);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("t1_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    checkOutput("t1_core_i_valid", bus.core_i_valid, 1);
    checkOutput("t1_core_msg",     bus.core_msg,     4);
    checkOutput("t1_core_key",     bus.core_key,     13);
    checkOutput("t1_core_modulus", bus.core_modulus, 497);
    waitRsp("t1_rsp_wait");
    checkOutput("t1_rsp_valid", bus.rsp_valid, 4'b0100);
    checkOutput("t1_rsp_out",   bus.rsp_out,   445);
    @(negedge clk);
    checkOutput("t1_done_cnt", bus.done_cnt, 1);
    checkOutput("t1_busy",     bus.busy,     0);

    // All four requesting continuously for eight jobs.
    doReset();
    grantLog.delete();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 2 + i, 3 + i, 1000 + 7 * i);
    bus.req_valid = '1;
    waitResponses(8, 1, "t2_jobs");
    checkOutput("t2_done_cnt", bus.done_cnt, 8);
    checkOutput("t2_grant_count", grantLog.size(), 8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++)
      checkOutput($sformatf("t2_grant_%0d", i), grantLog[i], expOrder[i]);

    // Core stalls in ISSUE while requester 1 changes its message after accept.
    stallCycles = 10;
    applyStimulus(1, 32'h11, 7, 1009);
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    checkOutput("t3_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    applyStimulus(1, 32'h99, 7, 1009);
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("t3_core_msg_held", bus.core_msg,     32'h11);
      checkOutput("t3_issue_held",    bus.core_i_valid, 1);
      checkOutput("t3_busy",          bus.busy,         1);
      checkOutput("t3_no_grant",      bus.req_ready,    0);
    end
    waitResponses(1, 1, "t3_job");
    stallCycles = 0;

    // Requester 3 withholds rsp_ready for 20 cycles: 3^5 mod 100 = 43.
    applyStimulus(3, 3, 5, 100);
    bus.rsp_ready = 4'b0111;
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    @(negedge clk);
    waitRsp("t4_rsp_wait");
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("t4_rsp_valid_held", bus.rsp_valid, 4'b1000);
      checkOutput("t4_rsp_out_held",   bus.rsp_out,   43);
      checkOutput("t4_no_grant",       bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = '1;
    @(negedge clk);
    checkOutput("t4_hs_rsp_valid", bus.rsp_valid, 4'b1000);
    checkOutput("t4_hs_no_grant",  bus.req_ready, 0);
    @(negedge clk);
    checkOutput("t4_next_grant", bus.req_ready, 4'b0001);
    checkOutput("t4_idle",       bus.busy,      0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    waitResponses(1, 1, "t4_job0");

    // Reset while the core is working on requester 2's job.
    applyStimulus(2, 9, 9, 77);
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("t5_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 0;
    while (!bus.core_o_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) timeoutFail("t5_wait_state");
    #2 rst = 1;
    #1;
    checkOutput("t5_busy",         bus.busy,         0);
    checkOutput("t5_core_o_ready", bus.core_o_ready, 0);
    checkOutput("t5_core_i_valid", bus.core_i_valid, 0);
    checkOutput("t5_rsp_valid",    bus.rsp_valid,    0);
    checkOutput("t5_owner",        bus.owner,        0);
    checkOutput("t5_done_cnt",     bus.done_cnt,     0);
    checkOutput("t5_core_msg",     bus.core_msg,     0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("t5_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    bus.req_valid = '1;
    @(negedge clk);
    checkOutput("t5_first_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    waitResponses(1, 1, "t5_job");

    // Seventeen jobs wrap the 4-bit counter.
    doReset();
    bus.req_valid = '1;
    waitResponses(15, 0, "t6_jobs15");
    checkOutput("t6_cnt15", bus.done_cnt, 15);
    waitResponses(1, 0, "t6_job16");
    checkOutput("t6_cnt_wrap", bus.done_cnt, 0);
    waitResponses(1, 1, "t6_job17");
    checkOutput("t6_cnt_after_wrap", bus.done_cnt, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
